// File: rtl/aib_pkg.sv
// rtl/aib_pkg.sv - shared types and lane patterns for the AIB TX framer
package aib_pkg;

  localparam int AIB_LANE_W    = 20;
  localparam int AIB_WORD_W    = 40;
  localparam int AIB_PAYLOAD_W = AIB_WORD_W - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAIN = 2'd1,
    MARK  = 2'd2,
    RUN   = 2'd3
  } tx_framer_state_e;

  localparam logic [AIB_LANE_W-1:0] TRAIN_PAT0 = 20'hF0F0F;
  localparam logic [AIB_LANE_W-1:0] TRAIN_PAT1 = 20'h0F0F0;
  localparam logic [AIB_LANE_W-1:0] MARK_PAT0  = 20'hFFFFF;
  localparam logic [AIB_LANE_W-1:0] MARK_PAT1  = 20'h00000;

  // The wire MSB flags a real word so the idle word (all zero) is distinguishable.
  function automatic logic [AIB_WORD_W-1:0] frame_word(input logic [AIB_PAYLOAD_W-1:0] payload);
    return {1'b1, payload};
  endfunction

endpackage

// File: rtl/aib_tx_fifo.sv
// rtl/aib_tx_fifo.sv - payload FIFO with flush and a combinational head output
module aib_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 39
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  // Extra pointer bit separates full from empty when the indices match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/aib_tx_framer.sv
// rtl/aib_tx_framer.sv - AIB TX framer: link training, alignment marker, SDR/DDR payload streaming
module aib_tx_framer
  import aib_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TRAIN_CNT_W = 8
) (
  input  logic                     i_tx_clk,
  input  logic                     i_rst,
  input  logic                     c_tx_en,
  input  logic                     c_chn_ddr_mode,
  input  logic [TRAIN_CNT_W-1:0]   c_train_len,
  input  logic [AIB_PAYLOAD_W-1:0] i_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [AIB_LANE_W-1:0]    o_tx_data0,
  output logic [AIB_LANE_W-1:0]    o_tx_data1,
  output logic [1:0]               o_tx_state,
  output logic                     o_training_done
);

  tx_framer_state_e          r_state;
  tx_framer_state_e          w_state_nxt;
  logic [TRAIN_CNT_W-1:0]    r_train_cnt;
  logic [TRAIN_CNT_W-1:0]    w_train_cnt_nxt;

  logic                      r_phase;
  logic [AIB_LANE_W-1:0]     r_hi;
  logic                      r_hi_pop;
  logic                      r_training_done;
  logic [AIB_LANE_W-1:0]     r_data0;
  logic [AIB_LANE_W-1:0]     r_data1;

  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic [AIB_PAYLOAD_W-1:0]  w_fifo_head;
  logic                      w_accept;
  logic                      w_run_beat;
  logic                      w_emit;
  logic                      w_bypass;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_flush;
  logic [AIB_WORD_W-1:0]     w_word;
  logic [AIB_LANE_W-1:0]     w_data0_nxt;
  logic [AIB_LANE_W-1:0]     w_data1_nxt;

  aib_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (AIB_PAYLOAD_W)
  ) u_fifo (
    .i_clk   (i_tx_clk),
    .i_rst   (i_rst),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_data  (i_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign o_ready         = (r_state != IDLE) & ~w_fifo_full;
  assign o_tx_state      = r_state;
  assign o_training_done = r_training_done;
  assign o_tx_data0      = r_data0;
  assign o_tx_data1      = r_data1;

  always_ff @(posedge i_tx_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_train_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_train_cnt <= w_train_cnt_nxt;
    end
  end

  // The train counter holds the beats still to show, including the one on the lanes.
  always_comb begin
    w_state_nxt     = r_state;
    w_train_cnt_nxt = r_train_cnt;
    if (!c_tx_en) begin
      w_state_nxt     = IDLE;
      w_train_cnt_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (c_train_len != '0) begin
            w_state_nxt     = TRAIN;
            w_train_cnt_nxt = c_train_len;
          end else begin
            w_state_nxt = MARK;
          end
        end
        TRAIN: begin
          if (r_train_cnt == TRAIN_CNT_W'(1)) begin
            w_state_nxt     = MARK;
            w_train_cnt_nxt = '0;
          end else begin
            w_train_cnt_nxt = r_train_cnt - TRAIN_CNT_W'(1);
          end
        end
        MARK:    w_state_nxt = RUN;
        default: w_state_nxt = RUN;
      endcase
    end
  end

  assign w_flush    = ~c_tx_en;
  assign w_accept   = i_valid & o_ready;
  assign w_run_beat = (w_state_nxt == RUN);
  assign w_emit     = w_run_beat & (c_chn_ddr_mode | ~r_phase);
  assign w_bypass   = w_emit & w_fifo_empty & w_accept;
  assign w_push     = w_accept & ~w_bypass;

  // In SDR the head stays in the FIFO until its HIGH beat has gone out.
  assign w_pop = c_chn_ddr_mode ? (w_emit & ~w_fifo_empty)
                                : (w_run_beat & r_phase & r_hi_pop);

  always_comb begin
    w_word = '0;
    if (!w_fifo_empty)  w_word = frame_word(w_fifo_head);
    else if (w_bypass)  w_word = frame_word(i_data);
  end

  always_comb begin
    w_data0_nxt = '0;
    w_data1_nxt = '0;
    case (w_state_nxt)
      TRAIN: begin
        w_data0_nxt = TRAIN_PAT0;
        w_data1_nxt = c_chn_ddr_mode ? TRAIN_PAT1 : '0;
      end
      MARK: begin
        w_data0_nxt = MARK_PAT0;
        w_data1_nxt = c_chn_ddr_mode ? MARK_PAT1 : '0;
      end
      RUN: begin
        if (c_chn_ddr_mode) begin
          w_data0_nxt = w_word[AIB_LANE_W-1:0];
          w_data1_nxt = w_word[AIB_WORD_W-1:AIB_LANE_W];
        end else if (!r_phase) begin
          w_data0_nxt = w_word[AIB_LANE_W-1:0];
        end else begin
          w_data0_nxt = r_hi;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_tx_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data0         <= '0;
      r_data1         <= '0;
      r_training_done <= 1'b0;
      r_phase         <= 1'b0;
      r_hi            <= '0;
      r_hi_pop        <= 1'b0;
    end else begin
      r_data0         <= w_data0_nxt;
      r_data1         <= w_data1_nxt;
      r_training_done <= w_run_beat;
      if (w_emit && !c_chn_ddr_mode) begin
        r_phase  <= 1'b1;
        r_hi     <= w_word[AIB_WORD_W-1:AIB_LANE_W];
        r_hi_pop <= ~w_fifo_empty;
      end else begin
        r_phase  <= 1'b0;
        r_hi_pop <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aib_tx_framer.sv
// tb/tb_aib_tx_framer.sv - directed self-checking bench for aib_tx_framer
module tb_aib_tx_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        ddr;
  logic [7:0]  train_len;
  logic [38:0] data;
  logic        valid;
  logic        ready;
  logic [19:0] d0;
  logic [19:0] d1;
  logic [1:0]  state;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  aib_tx_framer #(.FIFO_DEPTH(4), .TRAIN_CNT_W(8)) dut (
    .i_tx_clk        (clk),
    .i_rst           (rst),
    .c_tx_en         (en),
    .c_chn_ddr_mode  (ddr),
    .c_train_len     (train_len),
    .i_data          (data),
    .i_valid         (valid),
    .o_ready         (ready),
    .o_tx_data0      (d0),
    .o_tx_data1      (d1),
    .o_tx_state      (state),
    .o_training_done (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; ddr = 1'b1; train_len = 8'd3; data = '0; valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state got=%0h exp=0", state); end
    n_cmp++; if (d0 !== 20'h0 || d1 !== 20'h0) begin n_bad++; $display("FAIL reset_lanes got=%h/%h exp=0/0", d0, d1); end
    n_cmp++; if (ready !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL reset_flags ready=%b done=%b exp=0/0", ready, done); end
  endtask

  task automatic test_train_ddr();
    logic [1:0]  es [5] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd3};
    logic [19:0] e0 [5] = '{20'hF0F0F, 20'hF0F0F, 20'hF0F0F, 20'hFFFFF, 20'h00000};
    logic [19:0] e1 [5] = '{20'h0F0F0, 20'h0F0F0, 20'h0F0F0, 20'h00000, 20'h00000};
    logic        ed [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ddr = 1'b1; train_len = 8'd3; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (state !== es[i] || d0 !== e0[i] || d1 !== e1[i] || done !== ed[i]) begin
        n_bad++;
        $display("FAIL train_ddr beat%0d got st=%0d %h/%h done=%b exp st=%0d %h/%h done=%b",
                 i, state, d0, d1, done, es[i], e0[i], e1[i], ed[i]);
      end
    end
  endtask

  task automatic test_ddr_bypass();
    data = 39'h12345_6789A; valid = 1'b1;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL bypass_ready got=%b exp=1", ready); end
    tick();
    valid = 1'b0;
    n_cmp++; if (d0 !== 20'h6789A || d1 !== 20'h92345) begin n_bad++; $display("FAIL bypass_word got=%h/%h exp=6789a/92345", d0, d1); end
    tick();
    n_cmp++; if (d0 !== 20'h0 || d1 !== 20'h0) begin n_bad++; $display("FAIL bypass_idle got=%h/%h exp=0/0", d0, d1); end
  endtask

  task automatic test_sdr();
    logic [19:0] e0 [6] = '{20'h00001, 20'h80000, 20'hFFFFF, 20'h80007, 20'h00000, 20'h00000};
    en = 1'b0;
    tick();
    n_cmp++; if (state !== 2'd0 || d0 !== 20'h0) begin n_bad++; $display("FAIL sdr_idle got st=%0d d0=%h exp st=0 d0=0", state, d0); end
    ddr = 1'b0; train_len = 8'd0; en = 1'b1;
    tick();
    n_cmp++; if (state !== 2'd2 || d0 !== 20'hFFFFF || d1 !== 20'h0) begin n_bad++; $display("FAIL sdr_mark got st=%0d %h/%h exp st=2 fffff/00000", state, d0, d1); end
    data = 39'h0_00001; valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) begin
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL sdr_ready got=%b exp=1", ready); end
        data = 39'h7_FFFFF;
      end else begin
        valid = 1'b0;
      end
      n_cmp++; if (d0 !== e0[i] || d1 !== 20'h0) begin n_bad++; $display("FAIL sdr_beat%0d got=%h/%h exp=%h/00000", i, d0, d1, e0[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] e0;
    logic [19:0] e1;
    logic        er;
    en = 1'b0;
    tick();
    ddr = 1'b1; train_len = 8'd8; en = 1'b1;
    tick();
    for (int c = 1; c <= 16; c++) begin
      if (c <= 4)       begin valid = 1'b1; data = 39'h10 + 39'(c - 1); end
      else if (c <= 10) begin valid = 1'b1; data = 39'h14; end
      else if (c == 11) begin valid = 1'b1; data = 39'h15; end
      else              valid = 1'b0;
      if (c <= 8)       begin e0 = 20'hF0F0F; e1 = 20'h0F0F0; end
      else if (c == 9)  begin e0 = 20'hFFFFF; e1 = 20'h00000; end
      else if (c <= 15) begin e0 = 20'h10 + 20'(c - 10); e1 = 20'h80000; end
      else              begin e0 = 20'h0; e1 = 20'h0; end
      er = (c <= 4) || (c >= 10);
      if (c <= 11) begin
        n_cmp++; if (ready !== er) begin n_bad++; $display("FAIL b2b_ready c%0d got=%b exp=%b", c, ready, er); end
      end
      n_cmp++; if (d0 !== e0 || d1 !== e1) begin n_bad++; $display("FAIL b2b_lanes c%0d got=%h/%h exp=%h/%h", c, d0, d1, e0, e1); end
      tick();
    end
  endtask

  task automatic test_sdr_drop();
    logic [1:0]  es [6] = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [19:0] e0 [6] = '{20'hF0F0F, 20'hF0F0F, 20'hFFFFF, 20'h0, 20'h0, 20'h0};
    en = 1'b0; valid = 1'b0;
    tick();
    ddr = 1'b0; train_len = 8'd2; en = 1'b1;
    tick();
    n_cmp++; if (d0 !== 20'hF0F0F || d1 !== 20'h0) begin n_bad++; $display("FAIL drop_train_sdr got=%h/%h exp=f0f0f/00000", d0, d1); end
    tick(); tick();
    data = 39'h0ABCDE; valid = 1'b1;
    tick();
    n_cmp++; if (d0 !== 20'hABCDE) begin n_bad++; $display("FAIL drop_low got=%h exp=abcde", d0); end
    data = 39'h3; en = 1'b0;
    tick();
    valid = 1'b0;
    n_cmp++; if (state !== 2'd0 || d0 !== 20'h0 || d1 !== 20'h0 || ready !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL drop_idle got st=%0d %h/%h ready=%b done=%b exp st=0 0/0 ready=0 done=0", state, d0, d1, ready, done);
    end
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++; if (state !== es[i] || d0 !== e0[i]) begin n_bad++; $display("FAIL drop_restart%0d got st=%0d d0=%h exp st=%0d d0=%h", i, state, d0, es[i], e0[i]); end
    end
  endtask

  task automatic test_async_reset();
    en = 1'b0;
    tick();
    ddr = 1'b1; train_len = 8'd1; en = 1'b1;
    tick(); tick(); tick();
    data = 39'h1; valid = 1'b1;
    tick();
    n_cmp++; if (d0 !== 20'h00001 || d1 !== 20'h80000) begin n_bad++; $display("FAIL arst_pre got=%h/%h exp=00001/80000", d0, d1); end
    data = 39'h2;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (state !== 2'd0 || d0 !== 20'h0 || d1 !== 20'h0 || done !== 1'b0 || ready !== 1'b0) begin
      n_bad++; $display("FAIL arst_now got st=%0d %h/%h done=%b ready=%b exp all 0", state, d0, d1, done, ready);
    end
    en = 1'b0; valid = 1'b0;
    tick();
    rst = 1'b0;
    tick(); tick();
    n_cmp++; if (state !== 2'd0 || d0 !== 20'h0 || d1 !== 20'h0) begin n_bad++; $display("FAIL arst_quiet got st=%0d %h/%h exp st=0 0/0", state, d0, d1); end
    en = 1'b1;
    tick();
    n_cmp++; if (state !== 2'd1 || d0 !== 20'hF0F0F) begin n_bad++; $display("FAIL arst_retrain got st=%0d d0=%h exp st=1 d0=f0f0f", state, d0); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_train_ddr();
    test_ddr_bypass();
    test_sdr();
    test_back_to_back();
    test_sdr_drop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
